cdec8_seq: RTL and testbench
============================

CDEC8_SEQ -- requirements
Module: cdec8_seq

Interface
REQ-001 SHALL have parameter ALU_PASS, default 5'h00, meaning the aluop code for R = XBUS.
REQ-002 SHALL have parameter ALU_INC, default 5'h01, meaning the aluop code for R = XBUS + 1.
REQ-003 SHALL have parameter ALU_ADD, default 5'h02, meaning the aluop code for R = XBUS + T, flags valid.
REQ-004 SHALL have port `clock`, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port `reset_N`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `I`, input, 8 bits: the instruction register from the datapath.
REQ-007 SHALL have port `SZCy`, input, 3 bits: flags {S,Z,Cy} from the datapath.
REQ-008 SHALL have port `run`, input, 1 bit: free-run enable, sampled in state F0.
REQ-009 SHALL have port `step`, input, 1 bit: single-instruction enable, sampled in state F0.
REQ-010 SHALL have port `ctrl`, output, 17 bits: {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]} to the datapath.
REQ-011 SHALL have port `state`, output, 8 bits: the current state code, for debug monitor address 0x0B.
REQ-012 SHALL have port `halted`, output, 1 bit: high while in HALT.
REQ-013 SHALL have port `illegal`, output, 1 bit: one-cycle pulse when an undefined opcode is decoded.

Function
REQ-014 ctrl field codes SHALL be:
- xsrc: 0 PC, 1 A, 2 B, 3 C, 4 R, 5 RDR, 6 FLG, F = 0xFF.
- xdst: 0 PC, 1 A, 2 B, 3 C, 4 MAR, 5 WDR, 6 T, 7 I, F = none.
- mmrw: 10 read (RDR captures data_in), 01 write, 00 idle.
REQ-015 The IDLE word SHALL be mmrw=00, fwr=0, rwr=0, xdst=F, aluop=ALU_PASS, xsrc=F; every field not listed for a state SHALL take its IDLE value.
REQ-016 ctrl SHALL be decoded combinationally from the state register, plus the F0 gating in REQ-018 and the JZ condition in REQ-024.
REQ-017 State codes and their ctrl words SHALL be:
- F0 = 00: PC->MAR.
- F1 = 01: read, xsrc=PC, ALU_INC, rwr.
- F2 = 02: R->PC.
- F3 = 03: RDR->I.
- DEC = 04: IDLE.
- O0 = 10: PC->MAR.
- O1 = 11: read, xsrc=PC, ALU_INC, rwr.
- O2 = 12: R->PC.
- E0 = 20, E1 = 21, E2 = 22: per opcode.
- HALT = FF: IDLE.
REQ-018 In F0, if run|step = 0, the block SHALL output IDLE and hold in F0; otherwise it SHALL output the F0 word and advance to F1.
REQ-019 The fixed state sequence SHALL be F0->F1->F2->F3->DEC and O0->O1->O2->E0.
REQ-020 DEC SHALL dispatch on I[7:4]; I[3:0] is ignored.
REQ-021 Opcodes 0 (NOP) and 4 (ADD) SHALL go from DEC to E0 for ADD or to F0 for NOP. Opcodes 1 (LDI), 2 (LD), 3 (ST), 5 (JMP) and 6 (JZ) SHALL go from DEC to O0. Opcode 7 (MOV B,A) SHALL go to E0. Opcode F (HLT) SHALL go to HALT.
REQ-022 Any other opcode SHALL pulse `illegal` during the DEC cycle and go to F0, i.e. act as a NOP.
REQ-023 Execute words SHALL be, with each listed sequence ending by a return to F0:
- LDI: E0 RDR->A.
- LD: E0 RDR->MAR, E1 read, E2 RDR->A.
- ST: E0 RDR->MAR, E1 A->WDR, E2 write.
- ADD: E0 B->T, E1 xsrc=A with ALU_ADD, rwr and fwr, E2 R->A.
- MOV: E0 A->B.
- JMP: E0 RDR->PC.
REQ-024 JZ SHALL output RDR->PC in E0 when SZCy[1]=1 and IDLE otherwise; either way the next state is F0.
REQ-025 Total cycle counts SHALL be: NOP 5, MOV 6, ADD 8, LDI/JMP/JZ 9, LD/ST 11.
REQ-026 HALT SHALL output IDLE with halted=1 and SHALL exit only by reset; run and step SHALL be ignored in HALT.
REQ-027 The block SHALL never assert mmrw=11 and SHALL never assert read and an xdst write of RDR in the same cycle.

Reset
REQ-028 While reset_N=0, the outputs SHALL be state=00 (F0), ctrl=IDLE, halted=0 and illegal=0; this SHALL take effect asynchronously, including in the middle of an instruction.
REQ-029 After reset_N is released, the first advance SHALL occur at the first rising edge with run|step=1.

Verification (bench connects cdec8_seq, the datapath and a 256-byte memory; reset with run=1 unless stated)
REQ-030 mem = 10 5A F0 -> after 9 cycles A=5A and PC=02; HALT is reached at cycle 14; halted=1 thereafter.
REQ-031 mem = 10 03 70 10 FE 40 F0 -> A=01, B=03, SZCy=001 (Cy=1, Z=0) after ADD.
REQ-032 mem = 10 77 30 80 10 00 20 80 F0 -> mem[80]=77 and A=77; mmrw=01 for exactly one cycle.
REQ-033 Two JZ cases:
- mem = 10 00 70 10 00 40 60 20 F0 ... with mem[20]=F0 -> Z=1, PC=20, HALT.
- The same program with mem[01]=01 -> Z=0, falls through to the F0 at address 08.
REQ-034 run=0 with mem = 10 11 10 22 -> state=00 and ctrl=IDLE for 20 cycles. Then a one-cycle step pulse -> exactly one LDI executes (A=11) and the block returns to F0 holding IDLE.
REQ-035 Two boundary cases:
- mem[0]=80 -> illegal=1 for one cycle in DEC and PC=01.
- reset_N pulsed low while state=11 -> state=00 and ctrl=IDLE immediately, with no memory write.

Source files
------------

// File: rtl/cdec8_seq.sv
`timescale 1ns/1ps
// cdec8_seq: control sequencer for the CDEC8 8-bit datapath.
// Fetches an instruction, fetches an operand byte when the opcode needs one,
// then runs up to three execute cycles. The ctrl word is decoded from the state
// register, the F0 run/step gate and, for JZ, the Z flag.
module cdec8_seq #(
  parameter logic [4:0] ALU_PASS = 5'h00,
  parameter logic [4:0] ALU_INC  = 5'h01,
  parameter logic [4:0] ALU_ADD  = 5'h02
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
  input  logic        step,
  output logic [16:0] ctrl,
  output logic [7:0]  state,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [7:0] {
    StF0   = 8'h00,
    StF1   = 8'h01,
    StF2   = 8'h02,
    StF3   = 8'h03,
    StDec  = 8'h04,
    StO0   = 8'h10,
    StO1   = 8'h11,
    StO2   = 8'h12,
    StE0   = 8'h20,
    StE1   = 8'h21,
    StE2   = 8'h22,
    StHalt = 8'hFF
  } state_e;

  // X-bus sources and destinations
  localparam logic [3:0] SrcPc   = 4'h0;
  localparam logic [3:0] SrcA    = 4'h1;
  localparam logic [3:0] SrcB    = 4'h2;
  localparam logic [3:0] SrcR    = 4'h4;
  localparam logic [3:0] SrcRdr  = 4'h5;
  localparam logic [3:0] SrcNone = 4'hF;
  localparam logic [3:0] DstPc   = 4'h0;
  localparam logic [3:0] DstA    = 4'h1;
  localparam logic [3:0] DstB    = 4'h2;
  localparam logic [3:0] DstMar  = 4'h4;
  localparam logic [3:0] DstWdr  = 4'h5;
  localparam logic [3:0] DstT    = 4'h6;
  localparam logic [3:0] DstI    = 4'h7;
  localparam logic [3:0] DstNone = 4'hF;

  localparam logic [1:0] MemIdle  = 2'b00;
  localparam logic [1:0] MemWrite = 2'b01;
  localparam logic [1:0] MemRead  = 2'b10;

  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLd  = 4'h2;
  localparam logic [3:0] OpSt  = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJz  = 4'h6;
  localparam logic [3:0] OpMov = 4'h7;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [16:0] IdleWord = {MemIdle, 1'b0, 1'b0, DstNone, ALU_PASS, SrcNone};

  function automatic logic [16:0] word(input logic [1:0] mmrw, input logic fwr, input logic rwr,
                                       input logic [3:0] xdst, input logic [4:0] aluop,
                                       input logic [3:0] xsrc);
    return {mmrw, fwr, rwr, xdst, aluop, xsrc};
  endfunction

  state_e      state_q, state_d;
  logic [16:0] ctrl_dec;
  logic [3:0]  op;
  logic        op_legal;
  logic        go;
  logic        unused_bits;

  assign op          = I[7:4];
  assign op_legal    = (op <= OpMov) || (op == OpHlt);
  assign go          = run | step;
  // Low opcode nibble and S/Cy flags play no part in sequencing.
  assign unused_bits = ^{I[3:0], SZCy[2], SZCy[0]};

  // Next-state selection: fixed fetch/operand chains, opcode dispatch in DEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StF0:  if (go) state_d = StF1;
      StF1:  state_d = StF2;
      StF2:  state_d = StF3;
      StF3:  state_d = StDec;
      StDec: begin
        case (op)
          OpAdd, OpMov:                   state_d = StE0;
          OpLdi, OpLd, OpSt, OpJmp, OpJz: state_d = StO0;
          OpHlt:                          state_d = StHalt;
          default:                        state_d = StF0;  // NOP and undefined opcodes
        endcase
      end
      StO0:   state_d = StO1;
      StO1:   state_d = StO2;
      StO2:   state_d = StE0;
      StE0:   state_d = (op == OpLd || op == OpSt || op == OpAdd) ? StE1 : StF0;
      StE1:   state_d = StE2;
      StE2:   state_d = StF0;
      StHalt: state_d = StHalt;
      default: state_d = StF0;
    endcase
  end

  // Control word decode from the current state (and opcode in execute states).
  always_comb begin
    ctrl_dec = IdleWord;
    case (state_q)
      StF0:       if (go) ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstMar, ALU_PASS, SrcPc);
      StO0:       ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstMar, ALU_PASS, SrcPc);
      StF1, StO1: ctrl_dec = word(MemRead, 1'b0, 1'b1, DstNone, ALU_INC, SrcPc);
      StF2, StO2: ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstPc, ALU_PASS, SrcR);
      StF3:       ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstI, ALU_PASS, SrcRdr);
      StE0: begin
        case (op)
          OpLdi:      ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstA, ALU_PASS, SrcRdr);
          OpLd, OpSt: ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstMar, ALU_PASS, SrcRdr);
          OpAdd:      ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstT, ALU_PASS, SrcB);
          OpMov:      ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstB, ALU_PASS, SrcA);
          OpJmp:      ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstPc, ALU_PASS, SrcRdr);
          OpJz: if (SZCy[1]) ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstPc, ALU_PASS, SrcRdr);
          default:    ctrl_dec = IdleWord;
        endcase
      end
      StE1: begin
        case (op)
          OpLd:    ctrl_dec = word(MemRead, 1'b0, 1'b0, DstNone, ALU_PASS, SrcNone);
          OpSt:    ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstWdr, ALU_PASS, SrcA);
          OpAdd:   ctrl_dec = word(MemIdle, 1'b1, 1'b1, DstNone, ALU_ADD, SrcA);
          default: ctrl_dec = IdleWord;
        endcase
      end
      StE2: begin
        case (op)
          OpLd:    ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstA, ALU_PASS, SrcRdr);
          OpSt:    ctrl_dec = word(MemWrite, 1'b0, 1'b0, DstNone, ALU_PASS, SrcNone);
          OpAdd:   ctrl_dec = word(MemIdle, 1'b0, 1'b0, DstA, ALU_PASS, SrcR);
          default: ctrl_dec = IdleWord;
        endcase
      end
      default: ctrl_dec = IdleWord;
    endcase
  end

  // Reset forces IDLE at once, even while run is high in F0.
  assign ctrl    = reset_N ? ctrl_dec : IdleWord;
  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign illegal = (state_q == StDec) && !op_legal;

  // State register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= StF0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_cdec8_seq.sv
`timescale 1ns/1ps
// tb_cdec8_seq: runs small CDEC8 programs through the sequencer, a datapath and
// a 256-byte memory, checking every cycle against per-instruction trace tables.
module tb_cdec8_seq;

  // Expected ctrl words {mmrw, fwr, rwr, xdst, aluop, xsrc}
  localparam logic [16:0] WIdle   = {2'b00, 2'b00, 4'hF, 5'h00, 4'hF};
  localparam logic [16:0] WPcMar  = {2'b00, 2'b00, 4'h4, 5'h00, 4'h0};
  localparam logic [16:0] WFetch  = {2'b10, 2'b01, 4'hF, 5'h01, 4'h0};
  localparam logic [16:0] WRPc    = {2'b00, 2'b00, 4'h0, 5'h00, 4'h4};
  localparam logic [16:0] WRdrI   = {2'b00, 2'b00, 4'h7, 5'h00, 4'h5};
  localparam logic [16:0] WRdrA   = {2'b00, 2'b00, 4'h1, 5'h00, 4'h5};
  localparam logic [16:0] WRdrMar = {2'b00, 2'b00, 4'h4, 5'h00, 4'h5};
  localparam logic [16:0] WRead   = {2'b10, 2'b00, 4'hF, 5'h00, 4'hF};
  localparam logic [16:0] WAWdr   = {2'b00, 2'b00, 4'h5, 5'h00, 4'h1};
  localparam logic [16:0] WWrite  = {2'b01, 2'b00, 4'hF, 5'h00, 4'hF};
  localparam logic [16:0] WBT     = {2'b00, 2'b00, 4'h6, 5'h00, 4'h2};
  localparam logic [16:0] WAdd    = {2'b00, 2'b11, 4'hF, 5'h02, 4'h1};
  localparam logic [16:0] WRA     = {2'b00, 2'b00, 4'h1, 5'h00, 4'h4};
  localparam logic [16:0] WAB     = {2'b00, 2'b00, 4'h2, 5'h00, 4'h1};
  localparam logic [16:0] WRdrPc  = {2'b00, 2'b00, 4'h0, 5'h00, 4'h5};

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [16:0] ctrl;
  logic [7:0]  state;
  logic        halted;
  logic        illegal;

  // Datapath state
  logic [7:0] pc, a, b, c, mar, wdr, t, ir, rdr, r;
  logic [2:0] flg;
  logic [7:0] mem [256];
  logic [7:0] prog [256];
  logic [7:0] xbus;
  logic [8:0] alu;

  int checks = 0;
  int failures = 0;
  int wr_total = 0;
  int ill_total = 0;

  cdec8_seq dut (
    .clock  (clock),
    .reset_N(reset_N),
    .I      (ir),
    .SZCy   (flg),
    .run    (run),
    .step   (step),
    .ctrl   (ctrl),
    .state  (state),
    .halted (halted),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath bus and ALU
  always_comb begin
    case (ctrl[3:0])
      4'h0:    xbus = pc;
      4'h1:    xbus = a;
      4'h2:    xbus = b;
      4'h3:    xbus = c;
      4'h4:    xbus = r;
      4'h5:    xbus = rdr;
      4'h6:    xbus = {5'b0, flg};
      default: xbus = 8'hFF;
    endcase
    case (ctrl[8:4])
      5'h01:   alu = {1'b0, xbus} + 9'd1;
      5'h02:   alu = {1'b0, xbus} + {1'b0, t};
      default: alu = {1'b0, xbus};
    endcase
  end

  // Datapath registers and memory; reset reloads memory from prog
  always @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pc <= 0; a <= 0; b <= 0; c <= 0; mar <= 0; wdr <= 0;
      t <= 0; ir <= 0; rdr <= 0; r <= 0; flg <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else begin
      if (ctrl[13]) r <= alu[7:0];
      if (ctrl[14]) flg <= {alu[7], alu[7:0] == 8'h00, alu[8]};
      case (ctrl[12:9])
        4'h0: pc <= xbus;
        4'h1: a <= xbus;
        4'h2: b <= xbus;
        4'h3: c <= xbus;
        4'h4: mar <= xbus;
        4'h5: wdr <= xbus;
        4'h6: t <= xbus;
        4'h7: ir <= xbus;
        default: ;
      endcase
      if (ctrl[16:15] == 2'b10) rdr <= mem[mar];
      if (ctrl[16:15] == 2'b01) mem[mar] <= wdr;
    end
  end

  // Reference model: cycle index within the instruction plus a queue holding the
  // post-DEC trace {state, ctrl} of the instruction being executed.
  int          k = 0;
  bit          halted_m = 0;
  logic [24:0] seq [$];
  logic [26:0] exp_v;
  logic [24:0] item;

  task automatic push_operand();
    seq.push_back({8'h10, WPcMar});
    seq.push_back({8'h11, WFetch});
    seq.push_back({8'h12, WRPc});
  endtask

  task automatic build(input logic [3:0] op);
    seq.delete();
    case (op)
      4'h1: begin push_operand(); seq.push_back({8'h20, WRdrA}); end
      4'h2: begin
        push_operand();
        seq.push_back({8'h20, WRdrMar}); seq.push_back({8'h21, WRead});
        seq.push_back({8'h22, WRdrA});
      end
      4'h3: begin
        push_operand();
        seq.push_back({8'h20, WRdrMar}); seq.push_back({8'h21, WAWdr});
        seq.push_back({8'h22, WWrite});
      end
      4'h4: begin
        seq.push_back({8'h20, WBT}); seq.push_back({8'h21, WAdd});
        seq.push_back({8'h22, WRA});
      end
      4'h5: begin push_operand(); seq.push_back({8'h20, WRdrPc}); end
      4'h6: begin push_operand(); seq.push_back({8'h20, flg[1] ? WRdrPc : WIdle}); end
      4'h7: seq.push_back({8'h20, WAB});
      default: ;
    endcase
  endtask

  // Per-cycle compare of {state, ctrl, halted, illegal}
  always @(negedge clock) begin
    exp_v = {8'h00, WIdle, 2'b00};
    if (!reset_N) begin
      k = 0;
      halted_m = 0;
      seq.delete();
    end else if (halted_m) begin
      exp_v = {8'hFF, WIdle, 2'b10};
    end else begin
      case (k)
        0: if (run | step) begin exp_v = {8'h00, WPcMar, 2'b00}; k = 1; end
        1: begin exp_v = {8'h01, WFetch, 2'b00}; k = 2; end
        2: begin exp_v = {8'h02, WRPc, 2'b00}; k = 3; end
        3: begin exp_v = {8'h03, WRdrI, 2'b00}; k = 4; end
        4: begin
          build(ir[7:4]);
          exp_v = {8'h04, WIdle, 1'b0, (ir[7:4] > 4'h7) && (ir[7:4] != 4'hF)};
          halted_m = (ir[7:4] == 4'hF);
          k = (seq.size() > 0) ? 5 : 0;
        end
        default: begin
          if (seq.size() > 0) begin
            item = seq.pop_front();
            exp_v = {item, 2'b00};
          end
          k = (seq.size() > 0) ? k + 1 : 0;
        end
      endcase
    end
    if (reset_N && ctrl[16:15] == 2'b01) wr_total++;
    if (reset_N && illegal) ill_total++;
    chk("cycle", {5'b0, state, ctrl, halted, illegal}, {5'b0, exp_v});
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic r_en);
    @(posedge clock);
    #1;
    reset_N = 1'b0;
    run = r_en;
    step = 1'b0;
    #1;
    chk("rst_state", state, 32'h00);
    chk("rst_ctrl", ctrl, WIdle);
    chk("rst_halted", halted, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_N = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  int n;
  int snap;

  initial begin
    clear_prog();

    // LDI A,5A ; HLT
    prog[0] = 8'h10; prog[1] = 8'h5A; prog[2] = 8'hF0;
    do_reset(1'b1);
    cycles(9);
    chk("ldi_a", a, 8'h5A);
    chk("ldi_pc", pc, 8'h02);
    cycles(4);
    chk("hlt_dec_state", state, 8'h04);
    chk("hlt_not_yet", halted, 0);
    cycles(1);
    chk("hlt_state", state, 8'hFF);
    chk("hlt_flag", halted, 1);
    step = 1'b1;
    cycles(3);
    chk("hlt_sticky", state, 8'hFF);
    step = 1'b0;

    // LDI A,03 ; MOV B,A ; LDI A,FE ; ADD ; HLT
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h03; prog[2] = 8'h70; prog[3] = 8'h10;
    prog[4] = 8'hFE; prog[5] = 8'h40; prog[6] = 8'hF0;
    do_reset(1'b1);
    run_to_halt(100, n);
    chk("add_cycles", n, 37);
    chk("add_a", a, 8'h01);
    chk("add_b", b, 8'h03);
    chk("add_flags", flg, 3'b001);

    // LDI A,77 ; ST [80] ; LDI A,00 ; LD [80] ; HLT
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h77; prog[2] = 8'h30; prog[3] = 8'h80;
    prog[4] = 8'h10; prog[5] = 8'h00; prog[6] = 8'h20; prog[7] = 8'h80; prog[8] = 8'hF0;
    do_reset(1'b1);
    snap = wr_total;
    run_to_halt(100, n);
    chk("ldst_cycles", n, 45);
    chk("st_mem80", mem[8'h80], 8'h77);
    chk("ld_a", a, 8'h77);
    chk("st_one_write", wr_total - snap, 1);

    // JZ taken: ADD gives 0 so jump to 20 where HLT sits
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h00; prog[2] = 8'h70; prog[3] = 8'h10; prog[4] = 8'h00;
    prog[5] = 8'h40; prog[6] = 8'h60; prog[7] = 8'h20; prog[8] = 8'hF0; prog[8'h20] = 8'hF0;
    do_reset(1'b1);
    run_to_halt(100, n);
    chk("jz_t_cycles", n, 46);
    chk("jz_t_flags", flg, 3'b010);
    chk("jz_t_pc", pc, 8'h21);  // HLT fetched from 20

    // JZ not taken: ADD gives 1, fall through to HLT at 08
    prog[1] = 8'h01;
    do_reset(1'b1);
    run_to_halt(100, n);
    chk("jz_n_cycles", n, 46);
    chk("jz_n_a", a, 8'h01);
    chk("jz_n_flags", flg, 3'b000);
    chk("jz_n_pc", pc, 8'h09);

    // run=0 holds in F0; a single step runs exactly one LDI
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h11; prog[2] = 8'h10; prog[3] = 8'h22;
    do_reset(1'b0);
    cycles(20);
    chk("hold_state", state, 8'h00);
    chk("hold_ctrl", ctrl, WIdle);
    chk("hold_pc", pc, 8'h00);
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(28);
    chk("step_a", a, 8'h11);
    chk("step_pc", pc, 8'h02);
    chk("step_state", state, 8'h00);
    chk("step_ctrl", ctrl, WIdle);

    // Undefined opcode 8x behaves as NOP with a one-cycle illegal pulse
    clear_prog();
    prog[0] = 8'h80;
    do_reset(1'b0);
    snap = ill_total;
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(13);
    chk("ill_pulses", ill_total - snap, 1);
    chk("ill_pc", pc, 8'h01);
    chk("ill_state", state, 8'h00);

    // Asynchronous reset in the middle of the LDI operand read
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h11; prog[2] = 8'hF0;
    do_reset(1'b1);
    snap = wr_total;
    n = 0;
    while (state != 8'h11 && n < 30) begin
      cycles(1);
      n++;
    end
    chk("reach_o1", state, 8'h11);
    #1;
    reset_N = 1'b0;
    #1;
    chk("midrst_state", state, 8'h00);
    chk("midrst_ctrl", ctrl, WIdle);
    chk("midrst_no_write", wr_total - snap, 0);
    run = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_N = 1'b1;
    cycles(3);
    chk("midrst_after", state, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
